// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package debounce_pkg;

    localparam int N_DEFAULT = 19;

    typedef enum logic [2:0] {
        zero    = 3'd0,
        wait1_1 = 3'd1,
        wait1_2 = 3'd2,
        wait1_3 = 3'd3,
        one     = 3'd4,
        wait0_1 = 3'd5,
        wait0_2 = 3'd6,
        wait0_3 = 3'd7
    } db_state_t;

endpackage

// File: rtl/debounce_sample_tick_gen.sv
// Free-running N-bit counter; m_tick marks the last count of each period.
module sample_tick_gen #(
    parameter int N = debounce_pkg::N_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic m_tick
);

    logic [N-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign m_tick = &cnt;

endmodule

// File: rtl/debounce_fsm.sv
// Mechanical switch debouncer: synchronizes sw and requires it to hold
// through several sample ticks before db follows.
//
// state   | meaning
// --------+-------------------------------------------
// zero    | settled low, db=0
// wait1_1 | sw seen high, waiting for 1st tick
// wait1_2 | sw still high, waiting for 2nd tick
// wait1_3 | sw still high, waiting for 3rd tick
// one     | settled high, db=1
// wait0_1 | sw seen low, waiting for 1st tick
// wait0_2 | sw still low, waiting for 2nd tick
// wait0_3 | sw still low, waiting for 3rd tick
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db
);

    logic      sw_meta;
    logic      sw_s;
    logic      m_tick;
    db_state_t state_q;
    db_state_t state_d;

    sample_tick_gen #(.N(N)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .m_tick (m_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= 1'b0;
            sw_s    <= 1'b0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= zero;
        end else begin
            state_q <= state_d;
        end
    end

    // A reversal of sw_s always wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        db      = 1'b0;
        case (state_q)
            zero: begin
                if (sw_s) state_d = wait1_1;
            end
            wait1_1: begin
                if (!sw_s)       state_d = zero;
                else if (m_tick) state_d = wait1_2;
            end
            wait1_2: begin
                if (!sw_s)       state_d = zero;
                else if (m_tick) state_d = wait1_3;
            end
            wait1_3: begin
                if (!sw_s)       state_d = zero;
                else if (m_tick) state_d = one;
            end
            one: begin
                db = 1'b1;
                if (!sw_s) state_d = wait0_1;
            end
            wait0_1: begin
                db = 1'b1;
                if (sw_s)        state_d = one;
                else if (m_tick) state_d = wait0_2;
            end
            wait0_2: begin
                db = 1'b1;
                if (sw_s)        state_d = one;
                else if (m_tick) state_d = wait0_3;
            end
            wait0_3: begin
                db = 1'b1;
                if (sw_s)        state_d = one;
                else if (m_tick) state_d = zero;
            end
            default: begin
                state_d = zero;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm with a short tick period (N=3, 8 cycles).
module tb_debounce_fsm;
    import debounce_pkg::*;

    localparam int N = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sw    = 1'b0;
    logic db;

    int   n_cmp    = 0;
    int   n_err    = 0;
    int   rise_cnt = 0;
    logic db_prev  = 1'b0;

    debounce_fsm #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .db    (db)
    );

    always #5 clk = ~clk;

    // Downstream rising-edge detector model.
    always @(negedge clk) begin
        if (db && !db_prev) rise_cnt++;
        db_prev = db;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_state(input db_state_t s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (dut.state_q == s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    int first;
    bit flag;
    bit ok;

    initial begin
        // reset with sw held high
        sw    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_db", db, 0);
        chk("rst_state", dut.state_q, zero);
        chk("rst_cnt", dut.u_tick.cnt, 0);
        chk("rst_sync", dut.sw_s, 0);
        reset = 1'b0;
        first = 0;
        flag  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("db_after_release", db, 0);
                chk("cnt_after_release", dut.u_tick.cnt, 1);
            end
            if (db && first == 0) first = c;
            if (first != 0 && !db) flag = 1'b1;
        end
        chk("rise_exact", first, 24);
        chk("rise_window", (first >= 16 && first <= 28), 1);
        chk("rise_held", flag, 0);
        chk("rise_count_1", rise_cnt, 1);

        // short release glitch must not disturb db
        flag = 1'b0;
        sw   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!db) flag = 1'b1;
        end
        sw = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (!db) flag = 1'b1;
        end
        chk("glitch_db", flag, 0);
        chk("glitch_state", dut.state_q, one);

        // clean release
        sw    = 1'b0;
        first = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!db && first == 0) first = c;
        end
        chk("fall_window", (first >= 16 && first <= 28), 1);
        chk("fall_state", dut.state_q, zero);

        // bounce: 3-cycle pulses never reach db
        flag = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c % 3 == 0) sw = ~sw;
            @(negedge clk);
            if (db) flag = 1'b1;
        end
        sw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (db) flag = 1'b1;
        end
        chk("bounce_db", flag, 0);
        chk("bounce_state", dut.state_q, zero);

        // second clean press: exactly one more edge
        sw    = 1'b1;
        first = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (db && first == 0) first = c;
        end
        chk("press2_window", (first >= 16 && first <= 28), 1);
        chk("rise_count_2", rise_cnt, 2);
        sw = 1'b0;
        repeat (40) @(negedge clk);
        chk("release2_db", db, 0);

        // reset in wait1_2 aborts immediately
        sw = 1'b1;
        wait_state(wait1_2, 40, ok);
        chk("reach_wait1_2", ok, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_state", dut.state_q, zero);
        chk("mid_rst_cnt", dut.u_tick.cnt, 0);
        chk("mid_rst_db", db, 0);
        sw = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        flag  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (db) flag = 1'b1;
        end
        chk("post_rst_db", flag, 0);
        chk("rise_count_rst", rise_cnt, 2);

        // drop sw_s exactly in the m_tick cycle of wait1_3
        sw = 1'b1;
        wait_state(wait1_3, 40, ok);
        chk("reach_wait1_3", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (dut.u_tick.cnt == 5) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("align_cnt5", ok, 1);
        sw = 1'b0;
        repeat (2) @(negedge clk);
        chk("tick_and_drop", {dut.m_tick, dut.sw_s}, 2'b10);
        chk("pre_tick_state", dut.state_q, wait1_3);
        @(negedge clk);
        chk("drop_wins_state", dut.state_q, zero);
        flag = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (db) flag = 1'b1;
        end
        chk("drop_wins_db", flag, 0);
        chk("rise_count_end", rise_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_fsm.md
DEBOUNCE_FSM -- requirements
Module: debounce_fsm

Interface
REQ-001 The module SHALL have parameter N, default 19, the sample-tick period exponent: one tick every 2^N clk cycles (about 10.5 ms at 50 MHz).
REQ-002 The module SHALL have port clk, input, 1 bit, the system clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, an asynchronous, active-high reset.
REQ-004 The module SHALL have port sw, input, 1 bit, the raw mechanical switch level (asynchronous, bouncing).
REQ-005 The module SHALL have port db, output, 1 bit, the debounced level, intended for the downstream rising-edge detector's level input.

Function
REQ-006 sw SHALL pass through a two-flop synchronizer; only the second-flop output sw_s is used internally.
REQ-007 An N-bit free-running counter SHALL increment every cycle and wrap from 2^N-1 to 0.
REQ-008 m_tick SHALL be high for exactly the one cycle in which the counter equals 2^N-1.
REQ-009 The Moore FSM SHALL have exactly eight states: zero, wait1_1, wait1_2, wait1_3, one, wait0_1, wait0_2, wait0_3.
REQ-010 In zero: if sw_s=1, go to wait1_1; otherwise stay in zero.
REQ-011 In wait1_k (k=1..3): if sw_s=0, go to zero; else if m_tick=1, go to wait1_(k+1), and from wait1_3 go to one; otherwise stay.
REQ-012 In one: if sw_s=0, go to wait0_1; otherwise stay in one.
REQ-013 In wait0_k (k=1..3): if sw_s=1, go to one; else if m_tick=1, go to wait0_(k+1), and from wait0_3 go to zero; otherwise stay.
REQ-014 When sw_s reverses in the same cycle as m_tick in any wait state, the reversal SHALL take priority and the FSM returns to zero or one respectively.
REQ-015 db SHALL be decoded from the state register only: 1 in one and wait0_1..3, 0 in zero and wait1_1..3; db never depends combinationally on sw.
REQ-016 After sw settles, db SHALL change no earlier than 2*2^N cycles and no later than 3*2^N+4 cycles later.
REQ-017 Any sw pulse or gap shorter than 2^N cycles SHALL never change db.
REQ-018 Undefined or illegal state encodings SHALL recover to zero on the next clock edge.

Reset
REQ-019 While reset is high, the state SHALL be zero, the counter 0, both synchronizer flops 0 and db 0, taking effect immediately without waiting for clk.
REQ-020 Reset asserted mid-operation SHALL abort any wait sequence; after release, sequencing restarts from zero with the counter at 0.

Structure
REQ-021 Package debounce_pkg SHALL hold the state enum typedef (db_state_t) and the default value of N.
REQ-022 The tick counter SHALL be the sub-module sample_tick_gen (parameter N; ports clk, reset, m_tick).
REQ-023 The synchronizer, state register and next-state/output logic SHALL reside in debounce_fsm.

Verification (bench uses N=3, tick period 8)
REQ-024 Reset pulse with sw=1 held: db=0 during reset and after release; db rises between cycle 16 and cycle 28 after release, then stays 1.
REQ-025 Bounce: sw toggles every 3 cycles for 60 cycles, then holds 0: db stays 0 throughout.
REQ-026 Release glitch: with db=1, drive sw=0 for 5 cycles, then 1 again: db stays 1 and the FSM returns to one.
REQ-027 Clean release: with db=1, sw=0 held: db falls between 16 and 28 cycles after the sw edge; the downstream edge detector sees exactly one rising edge per clean press.
REQ-028 Reset asserted while in wait1_2: state becomes zero, counter 0 and db 0 before the next clk edge; no db pulse follows.
REQ-029 Force sw_s=0 in the m_tick cycle while in wait1_3: next state is zero and db never asserts.
